// File: rtl/sce_imem_responder_if.sv
// SCE fetch handshake between the fetcher (master) and the instruction-memory responder (slave).
interface sce_imem_responder_if #(
    parameter int CMDW = 32,
    parameter int DW   = 32
);
    logic            REQ_VLD;
    logic [CMDW-1:0] REQ_INFO;
    logic            REQ_ACK;
    logic            RSP_VLD;
    logic [DW-1:0]   RSP_INFO;
    logic            RSP_ERR;
    logic            RSP_ACK;

    modport master (
        output REQ_VLD, REQ_INFO, RSP_ACK,
        input  REQ_ACK, RSP_VLD, RSP_INFO, RSP_ERR
    );

    modport slave (
        input  REQ_VLD, REQ_INFO, RSP_ACK,
        output REQ_ACK, RSP_VLD, RSP_INFO, RSP_ERR
    );
endinterface

// File: rtl/sce_imem_responder.sv
// Fetch responder: one-cycle synchronous memory read feeding an in-order response FIFO,
// with credit-based request flow control and a side preload write port.
module sce_imem_responder #(
    parameter int PAW  = 32,
    parameter int CMDW = 32,
    parameter int DW   = 32,
    parameter int MAW  = 10,
    parameter int RFD  = 4
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    sce_imem_responder_if.slave  fch,
    input  logic                 WR_EN,
    input  logic [MAW-1:0]       WR_ADDR,
    input  logic [DW-1:0]        WR_DATA
);
    localparam int PW = $clog2(RFD);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem [2**MAW];
    logic [DW-1:0] rd_data_q;
    logic          rd_err_q;
    logic          inflight_q;
    logic [DW:0]   fifo_q [RFD];
    logic [DW:0]   push_data;
    logic [DW:0]   head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          req_ack_q;
    logic          accept, pop, push, req_err, rsp_vld;

    assign accept  = fch.REQ_VLD && req_ack_q;
    assign rsp_vld = (cnt_q != '0);
    assign pop     = rsp_vld && fch.RSP_ACK;
    assign push    = inflight_q;
    assign req_err = (fch.REQ_INFO[PAW-3:MAW] != '0) || (fch.REQ_INFO[CMDW-1:PAW-2] != '0);

    // Nonblocking read and write on the same edge give read-first collision behaviour.
    always_ff @(posedge CLK) begin
        if (WR_EN) mem[WR_ADDR] <= WR_DATA;
        if (accept) begin
            rd_data_q <= mem[fch.REQ_INFO[MAW-1:0]];
            rd_err_q  <= req_err;
        end
        if (push) fifo_q[wr_ptr_q] <= push_data;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        credit_d  = credit_q;
        push_data = {rd_err_q, rd_data_q};
        if (rd_err_q) push_data[DW-1:0] = '0;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        case ({accept, pop})
            2'b10:   credit_d = credit_q + 1'b1;
            2'b01:   credit_d = credit_q - 1'b1;
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            credit_q   <= '0;
            inflight_q <= 1'b0;
            req_ack_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            credit_q   <= credit_d;
            inflight_q <= accept;
            req_ack_q  <= (credit_d < CW'(RFD));
        end
    end

    assign head         = fifo_q[rd_ptr_q];
    assign fch.REQ_ACK  = req_ack_q;
    assign fch.RSP_VLD  = rsp_vld;
    assign fch.RSP_INFO = rsp_vld ? head[DW-1:0] : '0;
    assign fch.RSP_ERR  = rsp_vld && head[DW];

    a_no_overflow: assert property (@(posedge CLK) disable iff (!RSTN)
        !(push && (cnt_q == CW'(RFD))));
endmodule

// File: tb/tb_sce_imem_responder.sv
// Scoreboard bench for sce_imem_responder: expected words queued on accept, compared on pop.
module tb_sce_imem_responder;
    localparam int PAW  = 32;
    localparam int CMDW = 32;
    localparam int DW   = 32;
    localparam int MAW  = 10;
    localparam int RFD  = 4;

    logic           CLK = 1'b0;
    logic           RSTN;
    logic           WR_EN;
    logic [MAW-1:0] WR_ADDR;
    logic [DW-1:0]  WR_DATA;

    sce_imem_responder_if #(.CMDW(CMDW), .DW(DW)) fch ();

    sce_imem_responder #(
        .PAW(PAW), .CMDW(CMDW), .DW(DW), .MAW(MAW), .RFD(RFD)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .fch(fch),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
    );

    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad = 0;
    int          pushes = 0;
    int          pops = 0;
    int          stalls = 0;
    logic        rand_ack = 1'b0;
    logic [DW-1:0] mdl [2**MAW];
    logic [DW:0] sbq [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, mirrors what the next rising edge will do.
    always @(negedge CLK) begin
        logic [CMDW-1:0] a;
        logic [DW:0]     e;
        if (!RSTN) begin
            sbq.delete();
        end else begin
            if (fch.RSP_VLD) begin
                chk("spurious_vld", 64'(sbq.size() == 0), 64'd0);
                if (fch.RSP_ACK && sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("rsp", 64'({fch.RSP_ERR, fch.RSP_INFO}), 64'(e));
                    pops++;
                end
            end
            if (fch.REQ_VLD && fch.REQ_ACK) begin
                a = fch.REQ_INFO;
                if ((a >> MAW) != '0) e = {1'b1, {DW{1'b0}}};
                else                  e = {1'b0, mdl[a[MAW-1:0]]};
                sbq.push_back(e);
                pushes++;
            end
        end
        if (WR_EN) mdl[WR_ADDR] = WR_DATA;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        if (rand_ack) begin
            fch.RSP_ACK = ($urandom_range(0, 3) != 0);
            WR_EN   = ($urandom_range(0, 7) == 0);
            WR_ADDR = MAW'($urandom);
            WR_DATA = $urandom;
        end
    endtask

    task automatic send(input logic [CMDW-1:0] a);
        int unsigned n = 0;
        logic ok;
        fch.REQ_VLD  = 1'b1;
        fch.REQ_INFO = a;
        do begin
            ok = fch.REQ_ACK;
            if (!ok) stalls++;
            tick();
            n++;
        end while (!ok && n < 64);
        if (!ok) chk("send_timeout", 64'd1, 64'd0);
        fch.REQ_VLD = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        fch.RSP_ACK = 1'b1;
        while (sbq.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        tick();
        chk("drain_empty", 64'(sbq.size()), 64'd0);
        chk("drain_vld", 64'(fch.RSP_VLD), 64'd0);
    endtask

    initial begin
        int acc;
        int p0, q0, s0;
        logic ok;
        RSTN = 1'b0; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
        fch.REQ_VLD = 1'b0; fch.REQ_INFO = '0; fch.RSP_ACK = 1'b0;
        tick(); tick();
        chk("rst_req_ack", 64'(fch.REQ_ACK), 64'd0);
        chk("rst_rsp_vld", 64'(fch.RSP_VLD), 64'd0);
        chk("rst_rsp_info", 64'(fch.RSP_INFO), 64'd0);
        chk("rst_rsp_err", 64'(fch.RSP_ERR), 64'd0);
        RSTN = 1'b1;
        tick();
        chk("rel_req_ack", 64'(fch.REQ_ACK), 64'd1);

        // Preload: random fill, then the directed words.
        for (int i = 0; i < 2**MAW; i++) begin
            WR_EN = 1'b1; WR_ADDR = MAW'(i); WR_DATA = $urandom;
            if (i < 4)  WR_DATA = 32'hA0 + 32'(i);
            if (i == 5) WR_DATA = 32'h11;
            tick();
        end
        WR_EN = 1'b0;

        // 1: back-to-back in-order fetch.
        fch.RSP_ACK = 1'b1;
        p0 = pops; s0 = stalls;
        for (int i = 0; i < 4; i++) send(CMDW'(i));
        tick(); tick(); tick();
        chk("t1_stalls", 64'(stalls - s0), 64'd0);
        chk("t1_consecutive", 64'(pops - p0), 64'd4);
        drain();

        // 2: credit limit with the consumer stalled.
        fch.RSP_ACK = 1'b0;
        acc = 0;
        fch.REQ_VLD = 1'b1; fch.REQ_INFO = 32'd10;
        for (int i = 0; i < 10; i++) begin
            ok = fch.REQ_ACK;
            tick();
            if (ok) begin acc++; fch.REQ_INFO = CMDW'(10 + acc); end
        end
        chk("t2_accepts", 64'(acc), 64'd4);
        chk("t2_ack_low", 64'(fch.REQ_ACK), 64'd0);
        fch.RSP_ACK = 1'b1;
        tick();
        fch.RSP_ACK = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            ok = fch.REQ_ACK;
            tick();
            if (ok) begin acc++; fch.REQ_INFO = CMDW'(14 + acc); end
        end
        chk("t2_one_more", 64'(acc), 64'd1);
        fch.REQ_VLD = 1'b0;
        drain();

        // 3: out-of-range address.
        send(32'h400);
        drain();
        chk("t3_credit_back", 64'(fch.REQ_ACK), 64'd1);

        // 4: read-first collision, then the new value.
        chk("t4_ack", 64'(fch.REQ_ACK), 64'd1);
        fch.REQ_VLD = 1'b1; fch.REQ_INFO = 32'd5;
        WR_EN = 1'b1; WR_ADDR = 10'd5; WR_DATA = 32'h55;
        tick();
        fch.REQ_VLD = 1'b0; WR_EN = 1'b0;
        send(32'd5);
        drain();
        chk("t4_model", 64'(mdl[5]), 64'h55);

        // 5: reset with three queued responses and one read in flight.
        fch.RSP_ACK = 1'b0;
        for (int i = 0; i < 4; i++) send(CMDW'(i));
        RSTN = 1'b0;
        tick();
        chk("t5_rsp_vld", 64'(fch.RSP_VLD), 64'd0);
        chk("t5_rsp_info", 64'(fch.RSP_INFO), 64'd0);
        RSTN = 1'b1;
        tick();
        chk("t5_req_ack", 64'(fch.REQ_ACK), 64'd1);
        for (int i = 0; i < 6; i++) begin
            chk("t5_no_stale", 64'(fch.RSP_VLD), 64'd0);
            tick();
        end
        fch.RSP_ACK = 1'b1;
        for (int i = 0; i < 4; i++) send(CMDW'(i));
        drain();

        // 6: random consumer stalls and preload writes over many FIFO wraps.
        p0 = pops; q0 = pushes;
        rand_ack = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            if ($urandom_range(0, 15) == 0) send(32'h400 | CMDW'($urandom_range(0, 1023)));
            else                            send(CMDW'($urandom_range(0, 1023)));
        end
        rand_ack = 1'b0;
        WR_EN = 1'b0;
        drain();
        chk("t6_accepts", 64'(pushes - q0), 64'd1000);
        chk("t6_pops", 64'(pops - p0), 64'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end
endmodule
